// File: rtl/mac_sched_pkg.sv
// Shared types and defaults for the MAC tile scheduler.
package mac_sched_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_RES,
    EMIT,
    DONE
  } sched_state_t;

endpackage

// File: rtl/mac_sched_acc.sv
// Lane-wise accumulator register: load or add a result vector.
// Define MAC_SCHED_SAT_EN to saturate lane sums instead of wrapping.
module mac_sched_acc #(
  parameter int TILE_SIZE = 4,
  parameter int ACC_WIDTH = 32
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                load,
  input  logic                                add,
  input  logic [TILE_SIZE-1:0][ACC_WIDTH-1:0] in_vec,
  output logic [TILE_SIZE-1:0][ACC_WIDTH-1:0] acc_vec
);

  function automatic logic [ACC_WIDTH-1:0] lane_add(input logic [ACC_WIDTH-1:0] a,
                                                    input logic [ACC_WIDTH-1:0] b);
    logic [ACC_WIDTH:0] s;
    s = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
`ifdef MAC_SCHED_SAT_EN
    // Sign-extended sum disagreeing in its top two bits means overflow.
    if (s[ACC_WIDTH] != s[ACC_WIDTH-1])
      return s[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
`endif
    return s[ACC_WIDTH-1:0];
  endfunction

  logic [TILE_SIZE-1:0][ACC_WIDTH-1:0] sum_vec;

  always_comb begin
    sum_vec = '0;
    for (int i = 0; i < TILE_SIZE; i++)
      sum_vec[i] = lane_add(acc_vec[i], in_vec[i]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      acc_vec <= '0;
    else if (load)
      acc_vec <= in_vec;
    else if (add)
      acc_vec <= sum_vec;
  end

endmodule

// File: rtl/mac_tile_scheduler.sv
// Sequences MAC runs per output group, accumulates results, emits group vectors.
// Optional MAC_SCHED_SAT_EN selects saturating lane addition in mac_sched_acc.
//
// state    | meaning
// IDLE     | waiting for a job configuration
// ISSUE    | requesting a MAC run start
// WAIT_RES | waiting for the MAC result vector
// EMIT     | presenting the accumulated group result
// DONE     | one-cycle job-complete pulse
module mac_tile_scheduler
  import mac_sched_pkg::*;
#(
  parameter int TILE_SIZE = 4,
  parameter int ACC_WIDTH = 32,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       cfg_valid,
  output logic                                       cfg_ready,
  input  logic [CNT_W-1:0]                           cfg_acc_len,
  input  logic [CNT_W-1:0]                           cfg_num_groups,
  output logic                                       mac_s_TVALID,
  input  logic                                       mac_s_TREADY,
  input  logic                                       mac_m_TVALID,
  output logic                                       mac_m_TREADY,
  input  logic signed [TILE_SIZE-1:0][ACC_WIDTH-1:0] mac_reduced_vec,
  output logic                                       out_TVALID,
  input  logic                                       out_TREADY,
  output logic signed [TILE_SIZE-1:0][ACC_WIDTH-1:0] out_vec,
  output logic                                       busy,
  output logic                                       done
);

  sched_state_t state, state_nxt;
  logic [CNT_W-1:0] acc_len_q, num_groups_q, tile_cnt, group_cnt;
  logic cfg_hs, res_hs, out_hs, cfg_zero, last_tile, last_group;
  logic [TILE_SIZE-1:0][ACC_WIDTH-1:0] acc_vec;

  assign cfg_hs     = cfg_valid && cfg_ready;
  assign res_hs     = (state == WAIT_RES) && mac_m_TVALID;
  assign out_hs     = (state == EMIT) && out_TREADY;
  assign cfg_zero   = (cfg_acc_len == '0) || (cfg_num_groups == '0);
  assign last_tile  = (tile_cnt == acc_len_q - CNT_W'(1));
  assign last_group = (group_cnt == num_groups_q - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (cfg_hs) state_nxt = cfg_zero ? DONE : ISSUE;
      ISSUE:    if (mac_s_TREADY) state_nxt = WAIT_RES;
      WAIT_RES: if (res_hs) state_nxt = last_tile ? EMIT : ISSUE;
      EMIT:     if (out_hs) state_nxt = last_group ? DONE : ISSUE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Result ready stays up in ISSUE: the MAC controller gates its start accept on it.
  always_comb begin
    cfg_ready    = 1'b0;
    mac_s_TVALID = 1'b0;
    mac_m_TREADY = 1'b0;
    out_TVALID   = 1'b0;
    done         = 1'b0;
    busy         = (state != IDLE);
    unique case (state)
      IDLE:     cfg_ready = 1'b1;
      ISSUE:    begin mac_s_TVALID = 1'b1; mac_m_TREADY = 1'b1; end
      WAIT_RES: mac_m_TREADY = 1'b1;
      EMIT:     out_TVALID = 1'b1;
      DONE:     done = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_len_q    <= '0;
      num_groups_q <= '0;
      tile_cnt     <= '0;
      group_cnt    <= '0;
    end else begin
      if (cfg_hs) begin
        acc_len_q    <= cfg_acc_len;
        num_groups_q <= cfg_num_groups;
        tile_cnt     <= '0;
        group_cnt    <= '0;
      end
      if (res_hs)
        tile_cnt <= last_tile ? '0 : tile_cnt + CNT_W'(1);
      if (out_hs)
        group_cnt <= group_cnt + CNT_W'(1);
    end
  end

  mac_sched_acc #(
    .TILE_SIZE (TILE_SIZE),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_acc (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (res_hs && (tile_cnt == '0)),
    .add     (res_hs && (tile_cnt != '0)),
    .in_vec  (mac_reduced_vec),
    .acc_vec (acc_vec)
  );

  assign out_vec = acc_vec;

endmodule
